// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped, write-back data cache:
//   - controller state encoding
//   - address field widths and bit positions (tag / index / offset)
//   - geometry constants
//   - byte-merge helper used for store hits
// No ports; imported by dcache and dcache_byte_sel.
// -----------------------------------------------------------------------------
package dcache_pkg;

    // Controller states; encoding is fixed so debug tools can decode it.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FETCH     = 2'd2
    } state_t;

    // Geometry
    localparam int NUM_BLOCKS = 8;
    localparam int BLOCK_W    = 32;
    localparam int BYTE_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int MEM_ADDR_W = 6;

    // Address fields: tag[7:5], index[4:2], offset[1:0]
    localparam int TAG_W   = 3;
    localparam int IDX_W   = 3;
    localparam int OFF_W   = 2;
    localparam int TAG_MSB = 7;
    localparam int TAG_LSB = 5;
    localparam int IDX_MSB = 4;
    localparam int IDX_LSB = 2;
    localparam int OFF_MSB = 1;
    localparam int OFF_LSB = 0;

    // Replace one byte of a block; byte 0 lives in bits [7:0].
    function automatic logic [BLOCK_W-1:0] merge_byte(
        input logic [BLOCK_W-1:0] blk,
        input logic [OFF_W-1:0]   off,
        input logic [BYTE_W-1:0]  data_byte
    );
        logic [BLOCK_W-1:0] res;
        res = blk;
        case (off)
            2'd0:    res[7:0]   = data_byte;
            2'd1:    res[15:8]  = data_byte;
            2'd2:    res[23:16] = data_byte;
            2'd3:    res[31:24] = data_byte;
            default: res        = blk;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dcache_byte_sel.sv
// -----------------------------------------------------------------------------
// dcache_byte_sel
// Purely combinational byte extractor: picks one byte of a 32-bit block.
// Ports:
//   block     in  32  cache block, byte 0 in [7:0]
//   offset    in  2   byte offset within the block
//   data_byte out 8   selected byte
// -----------------------------------------------------------------------------
module dcache_byte_sel
    import dcache_pkg::*;
(
    input  logic [BLOCK_W-1:0] block,
    input  logic [OFF_W-1:0]   offset,
    output logic [BYTE_W-1:0]  data_byte
);

    // Offset-driven byte multiplexer
    always_comb begin
        data_byte = 8'h00;
        case (offset)
            2'd0:    data_byte = block[7:0];
            2'd1:    data_byte = block[15:8];
            2'd2:    data_byte = block[23:16];
            2'd3:    data_byte = block[31:24];
            default: data_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/dcache.sv
// -----------------------------------------------------------------------------
// dcache
// Direct-mapped, write-back data cache: 8 blocks x 4 bytes, byte-wide CPU
// port, block-wide memory port.
// Ports:
//   CLK           in  1   clock
//   RESET         in  1   synchronous active-high reset
//   READ / WRITE  in  1   CPU load / store request (held while BUSYWAIT=1)
//   ADDRESS       in  8   byte address {tag[7:5], index[4:2], offset[1:0]}
//   WRITEDATA     in  8   store byte
//   READDATA      out 8   load byte (live on hit, holds last value on miss)
//   BUSYWAIT      out 1   CPU stall
//   mem_read      out 1   block fetch request
//   mem_write     out 1   block writeback request
//   mem_address   out 6   block address {tag, index}
//   mem_writedata out 32  writeback block
//   mem_readdata  in  32  fetched block
//   mem_busywait  in  1   memory busy
// -----------------------------------------------------------------------------
module dcache
    import dcache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [BYTE_W-1:0]     WRITEDATA,
    output logic [BYTE_W-1:0]     READDATA,
    output logic                  BUSYWAIT,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
);

    // Per-block storage; data and tag are not reset (valid gates their use).
    logic [NUM_BLOCKS-1:0] valid_r;
    logic [NUM_BLOCKS-1:0] dirty_r;
    logic [TAG_W-1:0]      tag_r  [0:NUM_BLOCKS-1];
    logic [BLOCK_W-1:0]    data_r [0:NUM_BLOCKS-1];

    state_t state_r;
    state_t next_state_s;
    // High during the first cycle of a memory state, where mem_busywait is
    // not yet meaningful.
    logic   first_r;

    logic [BYTE_W-1:0] readdata_r;

    logic [TAG_W-1:0]      tag_s;
    logic [IDX_W-1:0]      idx_s;
    logic [OFF_W-1:0]      off_s;
    logic                  hit_s;
    logic [BLOCK_W-1:0]    block_s;
    logic [BYTE_W-1:0]     byte_s;

    logic                  busywait_s;
    logic                  mem_read_s;
    logic                  mem_write_s;
    logic [MEM_ADDR_W-1:0] mem_address_s;
    logic [BLOCK_W-1:0]    mem_writedata_s;
    logic                  write_hit_s;
    logic                  fill_s;

    assign tag_s   = ADDRESS[TAG_MSB:TAG_LSB];
    assign idx_s   = ADDRESS[IDX_MSB:IDX_LSB];
    assign off_s   = ADDRESS[OFF_MSB:OFF_LSB];
    assign block_s = data_r[idx_s];
    assign hit_s   = valid_r[idx_s] & (tag_r[idx_s] == tag_s);

    dcache_byte_sel u_byte_sel (
        .block     (block_s),
        .offset    (off_s),
        .data_byte (byte_s)
    );

    // Next-state, stall and memory-request decode
    always_comb begin
        next_state_s    = state_r;
        busywait_s      = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        mem_address_s   = ADDRESS[TAG_MSB:IDX_LSB];
        mem_writedata_s = block_s;
        write_hit_s     = 1'b0;
        fill_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (READ | WRITE) begin
                    if (hit_s) begin
                        // A store wins when both requests are raised.
                        write_hit_s = WRITE;
                    end else begin
                        busywait_s = 1'b1;
                        if (valid_r[idx_s] & dirty_r[idx_s]) begin
                            next_state_s = ST_WRITEBACK;
                        end else begin
                            next_state_s = ST_FETCH;
                        end
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                busywait_s    = 1'b1;
                mem_write_s   = 1'b1;
                mem_address_s = {tag_r[idx_s], idx_s};
                if (!first_r && !mem_busywait) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_WRITEBACK;
                end
            end
            ST_FETCH: begin
                busywait_s = 1'b1;
                mem_read_s = 1'b1;
                if (!first_r && !mem_busywait) begin
                    next_state_s = ST_IDLE;
                    fill_s       = 1'b1;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register and first-cycle marker
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            first_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            first_r <= (next_state_s != state_r);
        end
    end

    // Valid/dirty bits: cleared by reset, set by fill or store hit
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_r <= 8'h00;
            dirty_r <= 8'h00;
        end else if (fill_s) begin
            valid_r[idx_s] <= 1'b1;
            dirty_r[idx_s] <= 1'b0;
        end else if (write_hit_s) begin
            dirty_r[idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
            dirty_r <= dirty_r;
        end
    end

    // Data/tag arrays: a transfer abandoned by reset leaves them untouched
    always_ff @(posedge CLK) begin
        if (!RESET && fill_s) begin
            data_r[idx_s] <= mem_readdata;
            tag_r[idx_s]  <= tag_s;
        end else if (!RESET && write_hit_s) begin
            data_r[idx_s] <= merge_byte(block_s, off_s, WRITEDATA);
        end
    end

    // Last hit byte, replayed on READDATA while there is no hit
    always_ff @(posedge CLK) begin
        if (RESET) begin
            readdata_r <= 8'h00;
        end else if (hit_s) begin
            readdata_r <= byte_s;
        end else begin
            readdata_r <= readdata_r;
        end
    end

    assign READDATA      = hit_s ? byte_s : readdata_r;
    assign BUSYWAIT      = RESET ? 1'b0 : busywait_s;
    assign mem_read      = mem_read_s;
    assign mem_write     = mem_write_s;
    assign mem_address   = mem_address_s;
    assign mem_writedata = mem_writedata_s;

endmodule

// File: tb/tb_dcache.sv
// -----------------------------------------------------------------------------
// tb_dcache
// Directed bench for dcache. A small memory model answers every request with
// the block held in mem_fill, asserting mem_busywait for mem_lat cycles of
// each request.
// -----------------------------------------------------------------------------
module tb_dcache;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    logic [31:0] mem_fill;
    int          mem_lat;
    int          mem_cnt = 0;
    logic        overlap_seen = 1'b0;

    int tests = 0;
    int fails = 0;

    dcache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 CLK = ~CLK;

    // Memory model: busy for the first mem_lat cycles of each request
    assign mem_readdata = mem_fill;
    assign mem_busywait = (mem_read | mem_write) && (mem_cnt < mem_lat);

    always @(posedge CLK) begin
        if (!(mem_read | mem_write) || !mem_busywait) begin
            mem_cnt <= 0;
        end else begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    always @(negedge CLK) begin
        if (mem_read && mem_write) begin
            overlap_seen <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    // Count cycles until BUSYWAIT drops, bounded at 40
    task automatic wait_ready(output int n);
        n = 0;
        while (BUSYWAIT && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h25;
        WRITEDATA = 8'h00; mem_fill = 32'h0; mem_lat = 0;
        #1;
        tests++; if (BUSYWAIT !== 1'b0) begin fails++; $display("FAIL rst_busy_during: got %0b want 0", BUSYWAIT); end
        tick(); tick();
        tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL rst_mem_read: got %0b want 0", mem_read); end
        tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL rst_mem_write: got %0b want 0", mem_write); end
        tests++; if (READDATA !== 8'h00) begin fails++; $display("FAIL rst_readdata: got %h want 00", READDATA); end
        READ = 1'b0; RESET = 1'b0;
        tick();
    endtask

    task automatic test_read_miss();
        int n;
        ADDRESS = 8'h25; READ = 1'b1; mem_fill = 32'hDDCCBBAA; mem_lat = 3;
        #1;
        tests++; if (BUSYWAIT !== 1'b1) begin fails++; $display("FAIL rm_busy: got %0b want 1", BUSYWAIT); end
        tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL rm_idle_mem_read: got %0b want 0", mem_read); end
        tick();
        tests++; if (mem_read !== 1'b1) begin fails++; $display("FAIL rm_fetch_read: got %0b want 1", mem_read); end
        tests++; if (mem_address !== 6'h09) begin fails++; $display("FAIL rm_fetch_addr: got %h want 09", mem_address); end
        tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL rm_fetch_write: got %0b want 0", mem_write); end
        wait_ready(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL rm_fetch_cycles: got %0d want 4", n); end
        tests++; if (READDATA !== 8'hBB) begin fails++; $display("FAIL rm_readdata: got %h want bb", READDATA); end
        tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL rm_after_read: got %0b want 0", mem_read); end
        READ = 1'b0;
        tick();
    endtask

    task automatic test_write_hit();
        ADDRESS = 8'h25; WRITEDATA = 8'h5A; WRITE = 1'b1;
        #1;
        tests++; if (BUSYWAIT !== 1'b0) begin fails++; $display("FAIL wh_busy: got %0b want 0", BUSYWAIT); end
        tests++; if (READDATA !== 8'hBB) begin fails++; $display("FAIL wh_old_byte: got %h want bb", READDATA); end
        tick();
        tests++; if ((mem_read | mem_write) !== 1'b0) begin fails++; $display("FAIL wh_no_traffic: got %0b%0b want 00", mem_read, mem_write); end
        WRITE = 1'b0; READ = 1'b1;
        #1;
        tests++; if (READDATA !== 8'h5A) begin fails++; $display("FAIL wh_readback: got %h want 5a", READDATA); end
        tests++; if (BUSYWAIT !== 1'b0) begin fails++; $display("FAIL wh_read_busy: got %0b want 0", BUSYWAIT); end
        READ = 1'b0;
        tick();
    endtask

    task automatic test_writeback();
        int n;
        int k;
        ADDRESS = 8'h45; READ = 1'b1; mem_fill = 32'h44332211; mem_lat = 2;
        #1;
        tests++; if (BUSYWAIT !== 1'b1) begin fails++; $display("FAIL wb_busy: got %0b want 1", BUSYWAIT); end
        tests++; if (READDATA !== 8'h5A) begin fails++; $display("FAIL wb_hold_readdata: got %h want 5a", READDATA); end
        tick();
        tests++; if (mem_write !== 1'b1) begin fails++; $display("FAIL wb_mem_write: got %0b want 1", mem_write); end
        tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL wb_mem_read: got %0b want 0", mem_read); end
        tests++; if (mem_address !== 6'h09) begin fails++; $display("FAIL wb_addr: got %h want 09", mem_address); end
        tests++; if (mem_writedata !== 32'hDDCC5AAA) begin fails++; $display("FAIL wb_data: got %h want ddcc5aaa", mem_writedata); end
        k = 0;
        while (!mem_read && k < 20) begin
            k++;
            tick();
        end
        tests++; if (k !== 3) begin fails++; $display("FAIL wb_cycles: got %0d want 3", k); end
        tests++; if (mem_address !== 6'h11) begin fails++; $display("FAIL wb_fetch_addr: got %h want 11", mem_address); end
        tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL wb_fetch_write: got %0b want 0", mem_write); end
        wait_ready(n);
        tests++; if (n !== 3) begin fails++; $display("FAIL wb_fetch_cycles: got %0d want 3", n); end
        tests++; if (READDATA !== 8'h22) begin fails++; $display("FAIL wb_readdata: got %h want 22", READDATA); end
        READ = 1'b0;
        tick();
    endtask

    task automatic test_write_miss();
        int n;
        ADDRESS = 8'h80; WRITE = 1'b1; WRITEDATA = 8'h77; mem_fill = 32'h0F0E0D0C; mem_lat = 3;
        #1;
        tests++; if (BUSYWAIT !== 1'b1) begin fails++; $display("FAIL wm_busy: got %0b want 1", BUSYWAIT); end
        tick();
        tests++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin fails++; $display("FAIL wm_fetch: got rd=%0b wr=%0b want rd=1 wr=0", mem_read, mem_write); end
        tests++; if (mem_address !== 6'h20) begin fails++; $display("FAIL wm_addr: got %h want 20", mem_address); end
        wait_ready(n);
        tests++; if (n + 1 !== 5) begin fails++; $display("FAIL wm_busy_cycles: got %0d want 5", n + 1); end
        tests++; if (READDATA !== 8'h0C) begin fails++; $display("FAIL wm_filled_byte: got %h want 0c", READDATA); end
        tick();
        WRITE = 1'b0; READ = 1'b1;
        #1;
        tests++; if (READDATA !== 8'h77) begin fails++; $display("FAIL wm_merged: got %h want 77", READDATA); end
        // Evict block 0 to see that the merged store left it dirty
        ADDRESS = 8'h00; mem_fill = 32'h0A0B0C0D; mem_lat = 1;
        #1;
        tests++; if (BUSYWAIT !== 1'b1) begin fails++; $display("FAIL wm_evict_busy: got %0b want 1", BUSYWAIT); end
        tick();
        tests++; if (mem_write !== 1'b1) begin fails++; $display("FAIL wm_dirty_wb: got %0b want 1", mem_write); end
        tests++; if (mem_address !== 6'h20) begin fails++; $display("FAIL wm_wb_addr: got %h want 20", mem_address); end
        tests++; if (mem_writedata !== 32'h0F0E0D77) begin fails++; $display("FAIL wm_wb_data: got %h want 0f0e0d77", mem_writedata); end
        wait_ready(n);
        tests++; if (BUSYWAIT !== 1'b0) begin fails++; $display("FAIL wm_evict_timeout: got %0b want 0", BUSYWAIT); end
        tests++; if (READDATA !== 8'h0D) begin fails++; $display("FAIL wm_evict_read: got %h want 0d", READDATA); end
        READ = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_fetch();
        int n;
        ADDRESS = 8'h25; READ = 1'b1; mem_fill = 32'h11223344; mem_lat = 5;
        #1;
        tests++; if (BUSYWAIT !== 1'b1) begin fails++; $display("FAIL rf_busy: got %0b want 1", BUSYWAIT); end
        tick();
        tests++; if (mem_read !== 1'b1) begin fails++; $display("FAIL rf_fetch: got %0b want 1", mem_read); end
        tick();
        RESET = 1'b1;
        #1;
        tests++; if (BUSYWAIT !== 1'b0) begin fails++; $display("FAIL rf_busy_in_reset: got %0b want 0", BUSYWAIT); end
        tick();
        tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL rf_abandon: got rd=%0b wr=%0b want 0 0", mem_read, mem_write); end
        tests++; if (READDATA !== 8'h00) begin fails++; $display("FAIL rf_readdata: got %h want 00", READDATA); end
        RESET = 1'b0;
        #1;
        tests++; if (BUSYWAIT !== 1'b1) begin fails++; $display("FAIL rf_remiss: got %0b want 1", BUSYWAIT); end
        ADDRESS = 8'h45;
        #1;
        tests++; if (BUSYWAIT !== 1'b1) begin fails++; $display("FAIL rf_inval_blk1: got %0b want 1", BUSYWAIT); end
        ADDRESS = 8'h00;
        #1;
        tests++; if (BUSYWAIT !== 1'b1) begin fails++; $display("FAIL rf_inval_blk0: got %0b want 1", BUSYWAIT); end
        tests++; if (READDATA !== 8'h00) begin fails++; $display("FAIL rf_hold_zero: got %h want 00", READDATA); end
        ADDRESS = 8'h25; mem_lat = 1;
        #1;
        wait_ready(n);
        tests++; if (BUSYWAIT !== 1'b0) begin fails++; $display("FAIL rf_refill_timeout: got %0b want 0", BUSYWAIT); end
        tests++; if (READDATA !== 8'h33) begin fails++; $display("FAIL rf_refill_data: got %h want 33", READDATA); end
        READ = 1'b0;
        tick();
    endtask

    task automatic test_read_write_both();
        int n;
        ADDRESS = 8'h26; READ = 1'b1; WRITE = 1'b1; WRITEDATA = 8'h99;
        #1;
        tests++; if (BUSYWAIT !== 1'b0) begin fails++; $display("FAIL rw_busy: got %0b want 0", BUSYWAIT); end
        tests++; if (READDATA !== 8'h22) begin fails++; $display("FAIL rw_old_byte: got %h want 22", READDATA); end
        tick();
        tests++; if ((mem_read | mem_write) !== 1'b0) begin fails++; $display("FAIL rw_no_traffic: got %0b%0b want 00", mem_read, mem_write); end
        WRITE = 1'b0;
        #1;
        tests++; if (READDATA !== 8'h99) begin fails++; $display("FAIL rw_written: got %h want 99", READDATA); end
        ADDRESS = 8'h46; mem_fill = 32'h55667788; mem_lat = 1;
        #1;
        tests++; if (BUSYWAIT !== 1'b1) begin fails++; $display("FAIL rw_evict_busy: got %0b want 1", BUSYWAIT); end
        tick();
        tests++; if (mem_write !== 1'b1) begin fails++; $display("FAIL rw_dirty: got %0b want 1", mem_write); end
        tests++; if (mem_writedata !== 32'h11993344) begin fails++; $display("FAIL rw_wb_data: got %h want 11993344", mem_writedata); end
        wait_ready(n);
        tests++; if (READDATA !== 8'h66) begin fails++; $display("FAIL rw_refill: got %h want 66", READDATA); end
        READ = 1'b0;
        tick();
        tests++; if (overlap_seen !== 1'b0) begin fails++; $display("FAIL rd_wr_overlap: got %0b want 0", overlap_seen); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_writeback();
        test_write_miss();
        test_reset_in_fetch();
        test_read_write_both();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
